// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush, forwarding selects and MDU busy window
// for the 5-stage pipeline; shadows the E/M/W destination info.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_md,
    input  logic       d_md_div,
    input  logic       d_hilo,
    output logic       stall_fd,
    output logic       flush_de,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt,
    output logic       md_busy
);

    logic [4:0] e_rs_q, e_rs_d;
    logic [4:0] e_rt_q, e_rt_d;
    logic [4:0] e_a3_q, e_a3_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic       e_md_q, e_md_d;
    logic       e_div_q, e_div_d;
    logic [4:0] m_rt_q, m_rt_d;
    logic [4:0] m_a3_q, m_a3_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_a3_q, w_a3_d;
    logic [3:0] cnt_q, cnt_d;

    logic data_stall;
    logic mdu_stall;
    logic busy_raw;
    logic stall;

    // A source stalls when a producer in E or M finishes too late for it.
    function automatic logic src_hazard(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] ea3,
        input logic [1:0] etn,
        input logic [4:0] ma3,
        input logic [1:0] mtn
    );
        return (r != 5'd0) && (tuse != 2'd3) &&
               (((r == ea3) && (tuse < etn)) ||
                ((r == ma3) && (tuse < mtn)));
    endfunction

    // Nearest matching stage decides; it forwards only if its value exists.
    function automatic logic [1:0] d_sel(
        input logic [4:0] r,
        input logic [4:0] ea3,
        input logic [1:0] etn,
        input logic [4:0] ma3,
        input logic [1:0] mtn,
        input logic [4:0] wa3
    );
        logic [1:0] sel;
        sel = 2'd0;
        priority case (1'b1)
            (r == 5'd0): sel = 2'd0;
            (r == ea3):  sel = (etn == 2'd0) ? 2'd1 : 2'd0;
            (r == ma3):  sel = (mtn == 2'd0) ? 2'd2 : 2'd0;
            (r == wa3):  sel = 2'd3;
            default:     sel = 2'd0;
        endcase
        return sel;
    endfunction

    // E-stage operand: a ready M result beats the W result.
    function automatic logic [1:0] e_sel(
        input logic [4:0] r,
        input logic [4:0] ma3,
        input logic [1:0] mtn,
        input logic [4:0] wa3
    );
        logic [1:0] sel;
        sel = 2'd0;
        priority case (1'b1)
            (r == 5'd0):                     sel = 2'd0;
            ((r == ma3) && (mtn == 2'd0)):   sel = 2'd2;
            (r == wa3):                      sel = 2'd3;
            default:                         sel = 2'd0;
        endcase
        return sel;
    endfunction

    // Stall decision and output selects, all forced low while in reset.
    always_comb begin
        busy_raw   = e_md_q | (cnt_q != 4'd0);
        data_stall = src_hazard(d_rs, d_tuse_rs, e_a3_q, e_tnew_q,
                                m_a3_q, m_tnew_q) |
                     src_hazard(d_rt, d_tuse_rt, e_a3_q, e_tnew_q,
                                m_a3_q, m_tnew_q);
        mdu_stall  = (d_md | d_hilo) & busy_raw;
        stall      = ~reset & (data_stall | mdu_stall);
        stall_fd   = stall;
        flush_de   = stall;
        md_busy    = ~reset & busy_raw;
        fwd_d_rs   = 2'd0;
        fwd_d_rt   = 2'd0;
        fwd_e_rs   = 2'd0;
        fwd_e_rt   = 2'd0;
        fwd_m_rt   = 1'b0;
        if (!reset) begin
            fwd_d_rs = d_sel(d_rs, e_a3_q, e_tnew_q,
                             m_a3_q, m_tnew_q, w_a3_q);
            fwd_d_rt = d_sel(d_rt, e_a3_q, e_tnew_q,
                             m_a3_q, m_tnew_q, w_a3_q);
            fwd_e_rs = e_sel(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
            fwd_e_rt = e_sel(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
            fwd_m_rt = (m_rt_q != 5'd0) && (m_rt_q == w_a3_q);
        end
    end

    // Next shadow state: bubble into E on stall, age tnew into M.
    always_comb begin
        e_rs_d   = stall ? 5'd0 : d_rs;
        e_rt_d   = stall ? 5'd0 : d_rt;
        e_a3_d   = stall ? 5'd0 : d_a3;
        e_tnew_d = stall ? 2'd0 : d_tnew;
        e_md_d   = stall ? 1'b0 : d_md;
        e_div_d  = stall ? 1'b0 : d_md_div;
        m_rt_d   = e_rt_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        w_a3_d   = m_a3_q;
        cnt_d    = cnt_q;
        if (e_md_q) begin
            cnt_d = e_div_q ? 4'(DIV_LAT) : 4'(MULT_LAT);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Shadow registers and MDU counter; reset beats every update.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs_q   <= 5'd0;
            e_rt_q   <= 5'd0;
            e_a3_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            e_md_q   <= 1'b0;
            e_div_q  <= 1'b0;
            m_rt_q   <= 5'd0;
            m_a3_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            w_a3_q   <= 5'd0;
            cnt_q    <= 4'd0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            e_md_q   <= e_md_d;
            e_div_q  <= e_div_d;
            m_rt_q   <= m_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
